// File: rtl/slip_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slip_io_pkg
// Description : Shared types and constants for the Slipstream I/O-space
//               cycle sequencer: sequencer state encoding, requester
//               identifiers, chip-select decode width and address field.
// Revision    : 1.0 - initial release
// ============================================================================
package slip_io_pkg;

    // Chip-select decode: the top two address bits pick one of four devices.
    localparam int IO_CS_W    = 4;
    localparam int IO_SEL_MSB = 7;
    localparam int IO_SEL_LSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } io_seq_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DSP = 1'b1
    } io_req_t;

    // 2-to-4 one-hot decode of the device-select field.
    function automatic logic [IO_CS_W-1:0] f_cs_decode(input logic [1:0] i_sel);
        logic [IO_CS_W-1:0] v_one;
        v_one = {{(IO_CS_W-1){1'b0}}, 1'b1};
        return v_one << i_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_io_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : m_io_cycle_sequencer
// Description : Shares the Slipstream I/O bus between a CPU and a DSP
//               requester. Round-robin arbitration in IDLE, then a timed
//               SETUP / STROBE / HOLD bus cycle with registered one-hot chip
//               selects and read/write strobes, followed by a one-cycle Ack
//               to the granted requester in DONE.
// Ports       : MasterClock, Reset (async, active-high)
//               Cpu*/Dsp*  : requester groups (Req, Wr, Addr, WData, Ack, RData)
//               IoAddr, IoWData, IoRData : shared bus
//               IoCs, IoRdStb, IoWrStb   : registered bus controls
// Revision    : 1.0 - initial release
// ============================================================================
module m_io_cycle_sequencer
    import slip_io_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                MasterClock,
    input  logic                Reset,
    input  logic                CpuReq,
    input  logic                CpuWr,
    input  logic [7:0]          CpuAddr,
    input  logic [7:0]          CpuWData,
    output logic                CpuAck,
    output logic [7:0]          CpuRData,
    input  logic                DspReq,
    input  logic                DspWr,
    input  logic [7:0]          DspAddr,
    input  logic [7:0]          DspWData,
    output logic                DspAck,
    output logic [7:0]          DspRData,
    output logic [7:0]          IoAddr,
    output logic [7:0]          IoWData,
    input  logic [7:0]          IoRData,
    output logic [IO_CS_W-1:0]  IoCs,
    output logic                IoRdStb,
    output logic                IoWrStb
);

    localparam logic [3:0] c_SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_HOLD_LD   = 4'(HOLD_CYC - 1);

    io_seq_state_t r_state;
    io_seq_state_t w_next_state;
    logic [3:0]    r_cnt;
    logic [3:0]    w_next_cnt;
    io_req_t       r_grant;
    io_req_t       r_last;
    logic          r_wr;

    logic          w_grant_en;
    io_req_t       w_sel;
    logic          w_capture;
    logic          w_next_wr;
    logic [7:0]    w_next_addr;
    logic [7:0]    w_next_wdata;
    logic          w_next_active;

    // ------------------------------------------------------------------
    // Next-state logic with inline 2-way round-robin arbiter.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_grant_en   = 1'b0;
        w_sel        = r_grant;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (CpuReq || DspReq) begin
                    w_grant_en = 1'b1;
                    if (CpuReq && DspReq) begin
                        w_sel = (r_last == REQ_CPU) ? REQ_DSP : REQ_CPU;
                    end else begin
                        w_sel = CpuReq ? REQ_CPU : REQ_DSP;
                    end
                    w_next_cnt   = c_SETUP_LD;
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_next_cnt   = c_STROBE_LD;
                    w_next_state = ST_STROBE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    // Read data is taken on the edge that ends the strobe.
                    w_capture    = ~r_wr;
                    w_next_cnt   = c_HOLD_LD;
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Values the bus will carry after this edge; the registered controls are
    // computed from them so IoCs and strobes line up with the new state.
    always_comb begin
        w_next_wr    = r_wr;
        w_next_addr  = IoAddr;
        w_next_wdata = IoWData;
        if (w_grant_en) begin
            if (w_sel == REQ_CPU) begin
                w_next_wr    = CpuWr;
                w_next_addr  = CpuAddr;
                w_next_wdata = CpuWData;
            end else begin
                w_next_wr    = DspWr;
                w_next_addr  = DspAddr;
                w_next_wdata = DspWData;
            end
        end
        w_next_active = (w_next_state == ST_SETUP) ||
                        (w_next_state == ST_STROBE) ||
                        (w_next_state == ST_HOLD);
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_grant <= REQ_CPU;
            r_last  <= REQ_DSP;   // CPU wins the first tie
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_wr    <= w_next_wr;
            if (w_grant_en) begin
                r_grant <= w_sel;
                r_last  <= w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered bus controls, acknowledges and read data.
    // ------------------------------------------------------------------
    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            IoAddr   <= 8'd0;
            IoWData  <= 8'd0;
            IoCs     <= '0;
            IoRdStb  <= 1'b0;
            IoWrStb  <= 1'b0;
            CpuAck   <= 1'b0;
            DspAck   <= 1'b0;
            CpuRData <= 8'd0;
            DspRData <= 8'd0;
        end else begin
            IoAddr  <= w_next_addr;
            IoWData <= w_next_wdata;
            IoCs    <= w_next_active ?
                       f_cs_decode(w_next_addr[IO_SEL_MSB:IO_SEL_LSB]) : '0;
            IoRdStb <= (w_next_state == ST_STROBE) && !w_next_wr;
            IoWrStb <= (w_next_state == ST_STROBE) &&  w_next_wr;
            CpuAck  <= (w_next_state == ST_DONE) && (r_grant == REQ_CPU);
            DspAck  <= (w_next_state == ST_DONE) && (r_grant == REQ_DSP);
            if (w_capture && (r_grant == REQ_CPU)) begin
                CpuRData <= IoRData;
            end
            if (w_capture && (r_grant == REQ_DSP)) begin
                DspRData <= IoRData;
            end
        end
    end

endmodule
`default_nettype wire
